// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns stage.
// Optional InvMixColumns support elsewhere is enabled with MIX_COLUMNS_INV_EN.
package aes_pkg;

  localparam int AES_NB = 4;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplies by any 4-bit constant (covers 1,2,3,9,b,d,e) from a doubling chain.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one 32-bit column (row 0 in the top byte).
// With MIX_COLUMNS_INV_EN defined, an inv input selects InvMixColumns.
module mix_single_column
  import aes_pkg::*;
(
  input  aes_col_t col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic     inv,
`endif
  output aes_col_t col_out
);

  logic [7:0] a    [AES_NB];
  logic [3:0] coef [AES_NB];
  logic [7:0] b;

  // Each matrix row is row 0 rotated right by the row index.
  always_comb begin
    col_out = '0;
    b       = '0;
    coef[0] = 4'h2;
    coef[1] = 4'h3;
    coef[2] = 4'h1;
    coef[3] = 4'h1;
`ifdef MIX_COLUMNS_INV_EN
    if (inv) begin
      coef[0] = 4'he;
      coef[1] = 4'hb;
      coef[2] = 4'hd;
      coef[3] = 4'h9;
    end
`endif
    for (int r = 0; r < AES_NB; r++) begin
      a[r] = col_in[31-8*r -: 8];
    end
    for (int r = 0; r < AES_NB; r++) begin
      b = '0;
      for (int j = 0; j < AES_NB; j++) begin
        b = b ^ gf_mul(a[j], coef[(j - r + AES_NB) % AES_NB]);
      end
      col_out[31-8*r -: 8] = b;
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: accepts a state, mixes COLS_PER_CYCLE columns per clock.
// Defining MIX_COLUMNS_INV_EN adds the in_inv port for InvMixColumns.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $fatal(1, "mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // The counter step truncates to 0 for four columns, so the counter simply stays put.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % AES_NB);
  localparam logic [1:0] LAST_COL = 2'(AES_NB - COLS_PER_CYCLE);

  mc_state_e  state_q, state_d;
  logic [1:0] col_q, col_d;
  aes_state_t data_q, data_d;
  aes_state_t result_q, result_d;
  logic       last_q, last_d;
`ifdef MIX_COLUMNS_INV_EN
  logic       inv_q, inv_d;
`endif

  logic [1:0] col_idx [COLS_PER_CYCLE];
  aes_col_t   src_col [COLS_PER_CYCLE];
  aes_col_t   mix_col [COLS_PER_CYCLE];

  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx[k] = col_q + 2'(k);
      src_col[k] = data_q[(AES_NB - 1 - int'(col_idx[k])) * 32 +: 32];
    end
  end

  generate
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
      mix_single_column u_mix (
        .col_in  (src_col[k]),
`ifdef MIX_COLUMNS_INV_EN
        .inv     (inv_q),
`endif
        .col_out (mix_col[k])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    data_d   = data_q;
    result_d = result_q;
    last_d   = last_q;
`ifdef MIX_COLUMNS_INV_EN
    inv_d    = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
`ifdef MIX_COLUMNS_INV_EN
          inv_d   = in_inv;
`endif
          col_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          result_d[(AES_NB - 1 - int'(col_idx[k])) * 32 +: 32] = last_q ? src_col[k] : mix_col[k];
        end
        col_d = col_q + COL_STEP;
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      last_q   <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      data_q   <= data_d;
      result_q <= result_d;
      last_q   <= last_d;
`ifdef MIX_COLUMNS_INV_EN
      inv_q    <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = result_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Drives three mix_columns_iter instances (1, 2 and 4 columns per cycle) in lockstep
// and checks them against a matrix-product GF(2^8) model; MIX_COLUMNS_INV_EN adds inverse checks.
module tb_mix_columns_iter;

  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_ready;
`ifdef MIX_COLUMNS_INV_EN
  logic         in_inv;
`endif
  logic         ir [NDUT];
  logic         ov [NDUT];
  logic [127:0] od [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_last(in_last),
`ifdef MIX_COLUMNS_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));

  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_last(in_last),
`ifdef MIX_COLUMNS_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));

  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_last(in_last),
`ifdef MIX_COLUMNS_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 1;
  endfunction

  // Carry-less product followed by polynomial reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c, input logic inv);
    logic [7:0]  row0 [4];
    logic [7:0]  a [4];
    logic [7:0]  acc;
    logic [31:0] res;
    if (inv) begin
      row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) acc = acc ^ gf_mult(row0[(j - r + 4) % 4], a[j]);
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] d, input logic last,
                                               input logic inv);
    logic [127:0] res;
    if (last) return d;
    res = '0;
    for (int c = 0; c < 4; c++) res[127-32*c -: 32] = model_col(d[127-32*c -: 32], inv);
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, latency checks per instance, optional stall, drain.
  task automatic run_txn(input string name, input logic [127:0] din, input logic last,
                         input logic inv, input logic [127:0] exp, input int hold);
    in_data  = din;
    in_last  = last;
`ifdef MIX_COLUMNS_INV_EN
    in_inv   = inv;
`endif
    in_valid = 1'b1;
    for (int i = 0; i < NDUT; i++) chk1($sformatf("%s d%0d in_ready idle", name, i), ir[i], 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_last  = 1'($urandom % 2);
`ifdef MIX_COLUMNS_INV_EN
    in_inv   = 1'($urandom % 2);
`endif
    for (int e = 1; e <= 4; e++) begin
      step();
      for (int i = 0; i < NDUT; i++) begin
        chk1($sformatf("%s d%0d out_valid e%0d", name, i, e), ov[i], e >= lat_of(i));
        chk1($sformatf("%s d%0d in_ready e%0d", name, i, e), ir[i], 1'b0);
        if (e == lat_of(i)) chk128($sformatf("%s d%0d out_data", name, i), od[i], exp);
      end
    end
    for (int h = 0; h < hold; h++) begin
      step();
      for (int i = 0; i < NDUT; i++) begin
        chk1($sformatf("%s d%0d hold out_valid h%0d", name, i, h), ov[i], 1'b1);
        chk128($sformatf("%s d%0d hold out_data h%0d", name, i, h), od[i], exp);
        chk1($sformatf("%s d%0d hold in_ready h%0d", name, i, h), ir[i], 1'b0);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      chk1($sformatf("%s d%0d drained out_valid", name, i), ov[i], 1'b0);
      chk1($sformatf("%s d%0d drained in_ready", name, i), ir[i], 1'b1);
    end
  endtask

  initial begin
    logic [127:0] d;
    logic         l;
    logic         v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    in_inv    = 1'b0;
`endif
    repeat (3) step();
    for (int i = 0; i < NDUT; i++) begin
      chk1($sformatf("reset d%0d out_valid", i), ov[i], 1'b0);
      chk128($sformatf("reset d%0d out_data", i), od[i], 128'h0);
      chk1($sformatf("reset d%0d in_ready", i), ir[i], 1'b1);
    end
    rst = 1'b0;
    step();

    run_txn("fips_r1", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
            128'h046681e5_e0cb199a_48f8d37a_2806264c, 0);
    run_txn("colvec_a", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0);
    run_txn("colvec_b", 128'hd4d4d4d5_2d26314c_db135345_f20a225c, 1'b0, 1'b0,
            128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, 0);
    run_txn("bypass", 128'h0123456789abcdef_0123456789abcdef, 1'b1, 1'b0,
            128'h0123456789abcdef_0123456789abcdef, 0);
    run_txn("backpressure", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
            128'h046681e5_e0cb199a_48f8d37a_2806264c, 10);

    in_data  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    in_last  = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      chk1($sformatf("midreset d%0d out_valid", i), ov[i], 1'b0);
      chk128($sformatf("midreset d%0d out_data", i), od[i], 128'h0);
      chk1($sformatf("midreset d%0d in_ready", i), ir[i], 1'b1);
    end
    run_txn("after_reset", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
            128'h046681e5_e0cb199a_48f8d37a_2806264c, 1);

`ifdef MIX_COLUMNS_INV_EN
    run_txn("inverse", 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0, 1'b1,
            128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 0);
    run_txn("inverse_bypass", 128'h0123456789abcdef_0123456789abcdef, 1'b1, 1'b1,
            128'h0123456789abcdef_0123456789abcdef, 0);
`endif

    for (int t = 0; t < 16; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      l = ($urandom % 4) == 0;
`ifdef MIX_COLUMNS_INV_EN
      v = 1'($urandom % 2);
`else
      v = 1'b0;
`endif
      run_txn($sformatf("rand%0d", t), d, l, v, model_state(d, l, v), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
